output_conditioner: RTL and testbench

- Counterpart to the input conditioner: drives a physical output pin instead of cleaning one.
- Takes a requested level and one-cycle pulse requests from core logic and turns them into a glitch-free registered pin waveform.
- Every high and low phase lasts at least T clock cycles.
- Gives edge strobes that match the conditioner's rising/falling outputs, so the same monitors work on both ends of a pin.

---
 rtl/output_conditioner.sv | 128 ++++++++++++
 tb/tb_output_conditioner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/output_conditioner.sv
// Registered, rate-limited pin driver: every level is held at least T cycles, with edge strobes.
// Optional `OUTCOND_PULSE_QUEUE_EN keeps one pulse request that arrives outside the accept window.
module output_conditioner #(
    parameter int T  = 4,
    parameter int CW = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    input  logic pulse,
    output logic pin,
    output logic rising,
    output logic falling,
    output logic busy
);

    typedef enum logic [1:0] {LOW_IDLE, HIGH_HOLD, HIGH_IDLE, LOW_HOLD} state_t;

    localparam logic [CW-1:0] HOLD = CW'(T - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pmode_q, pmode_d;
    logic          pin_q, pin_d;
    logic          rising_q, rising_d;
    logic          falling_q, falling_d;
    logic          busy_q, busy_d;
    logic          win, preq;

`ifdef OUTCOND_PULSE_QUEUE_EN
    logic pend_q, pend_d;
`endif

    // Pulses are only accepted while low and past the dwell.
    assign win = (state_q == LOW_IDLE) || (state_q == LOW_HOLD && cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pmode_d   = pmode_q;
        pin_d     = pin_q;
        rising_d  = 1'b0;
        falling_d = 1'b0;
        busy_d    = busy_q;
`ifdef OUTCOND_PULSE_QUEUE_EN
        preq   = pulse | pend_q;
        pend_d = win ? 1'b0 : (pend_q | pulse);
`else
        preq   = pulse;
`endif
        case (state_q)
            LOW_IDLE, LOW_HOLD: begin
                if (state_q == LOW_HOLD && cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (level_in || preq) begin
                    state_d  = HIGH_HOLD;
                    pin_d    = 1'b1;
                    rising_d = 1'b1;
                    cnt_d    = HOLD;
                    busy_d   = 1'b1;
                    pmode_d  = preq & ~level_in;
                end else begin
                    state_d = LOW_IDLE;
                    busy_d  = 1'b0;
                end
            end
            HIGH_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (level_in) begin
                    // A held level keeps the pin up even after a pulse-initiated high.
                    state_d = HIGH_IDLE;
                    busy_d  = 1'b0;
                    pmode_d = 1'b0;
                end else begin
                    state_d   = LOW_HOLD;
                    pin_d     = 1'b0;
                    falling_d = 1'b1;
                    cnt_d     = HOLD;
                    busy_d    = 1'b1;
                    pmode_d   = 1'b0;
                end
            end
            HIGH_IDLE: begin
                if (!level_in) begin
                    state_d   = LOW_HOLD;
                    pin_d     = 1'b0;
                    falling_d = 1'b1;
                    cnt_d     = HOLD;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = LOW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOW_IDLE;
            cnt_q     <= '0;
            pmode_q   <= 1'b0;
            pin_q     <= 1'b0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef OUTCOND_PULSE_QUEUE_EN
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pmode_q   <= pmode_d;
            pin_q     <= pin_d;
            rising_q  <= rising_d;
            falling_q <= falling_d;
            busy_q    <= busy_d;
`ifdef OUTCOND_PULSE_QUEUE_EN
            pend_q    <= pend_d;
`endif
        end
    end

    assign pin     = pin_q;
    assign rising  = rising_q;
    assign falling = falling_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_output_conditioner.sv
// Bench for output_conditioner: vector table, hand sequences, and a dwell-age reference model.
module tb_output_conditioner;
    localparam int T = 4;

    logic clk = 1'b0, rst_n = 1'b0, level_in = 1'b0, pulse = 1'b0;
    logic pin, rising, falling, busy;

    output_conditioner #(.T(T), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .level_in(level_in), .pulse(pulse),
        .pin(pin), .rising(rising), .falling(falling), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    // Reference model: pin level plus how many cycles it has shown that level.
    logic m_pin = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_pend = 1'b0;
    int   m_age = T + 1;

    typedef struct {
        logic       r, l, p;
        logic [3:0] e;   // {pin, rising, falling, busy}
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, l, p, input logic [3:0] e, input int n);
        vec_t v;
        v.r = r; v.l = l; v.p = p; v.e = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: pin/rise/fall/busy got %b expected %b", name, act, exp);
    endtask

    task automatic step(input logic r, l, p);
        rst_n = r; level_in = l; pulse = p;
        @(posedge clk);
        #1;
    endtask

    task automatic hs(input logic r, l, p, input logic [3:0] e, input string name);
        step(r, l, p);
        chk(name, {pin, rising, falling, busy}, e);
    endtask

    task automatic model(input logic r, l, p);
        logic win, preq;
        m_rise = 1'b0; m_fall = 1'b0;
        if (!r) begin
            m_pin = 1'b0; m_age = T + 1; m_pend = 1'b0;
        end else begin
            win = !m_pin && m_age >= T;
`ifdef OUTCOND_PULSE_QUEUE_EN
            preq = p | m_pend;
            if (win) m_pend = 1'b0; else if (p) m_pend = 1'b1;
`else
            preq = p;
`endif
            if (win && (l || preq)) begin
                m_pin = 1'b1; m_rise = 1'b1; m_age = 1;
            end else if (m_pin && m_age >= T && !l) begin
                m_pin = 1'b0; m_fall = 1'b1; m_age = 1;
            end else if (m_age <= T) begin
                m_age++;
            end
        end
    endtask

    task automatic mstep(input logic r, l, p, input string name);
        model(r, l, p);
        step(r, l, p);
        chk(name, {pin, rising, falling, busy}, {m_pin, m_rise, m_fall, (m_age <= T) ? 1'b1 : 1'b0});
    endtask

    initial begin
        int   edges, strobes, last_edge, cyc;
        logic prev;

        // Reset, steady request, release.
        add(0, 0, 0, 4'b0000, 2);
        add(1, 1, 0, 4'b1101, 1); add(1, 1, 0, 4'b1001, 3); add(1, 1, 0, 4'b1000, 2);
        add(1, 0, 0, 4'b0011, 1); add(1, 0, 0, 4'b0001, 3); add(1, 0, 0, 4'b0000, 1);
        // One-cycle level request.
        add(1, 1, 0, 4'b1101, 1); add(1, 0, 0, 4'b1001, 3); add(1, 0, 0, 4'b0011, 1);
        add(1, 0, 0, 4'b0001, 3); add(1, 0, 0, 4'b0000, 1);
        // Single pulse.
        add(1, 0, 1, 4'b1101, 1); add(1, 0, 0, 4'b1001, 3); add(1, 0, 0, 4'b0011, 1);
        add(1, 0, 0, 4'b0001, 3); add(1, 0, 0, 4'b0000, 2);
        // Request during low hold waits, then goes straight back high.
        add(1, 1, 0, 4'b1101, 1); add(1, 0, 0, 4'b1001, 3); add(1, 0, 0, 4'b0011, 1);
        add(1, 1, 0, 4'b0001, 3); add(1, 1, 0, 4'b1101, 1); add(1, 0, 0, 4'b1001, 3);
        add(1, 0, 0, 4'b0011, 1); add(1, 0, 0, 4'b0001, 3); add(1, 0, 0, 4'b0000, 1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].l, tbl[i].p);
            chk($sformatf("vec%0d", i), {pin, rising, falling, busy}, tbl[i].e);
        end

        // Reset in the middle of a high hold.
        hs(1, 1, 0, 4'b1101, "rst_pre_rise");
        hs(1, 1, 0, 4'b1001, "rst_pre_hold");
        hs(0, 1, 0, 4'b0000, "rst_mid_hold");
        hs(1, 1, 0, 4'b1101, "rst_after_rise");
        for (int i = 0; i < 3; i++) hs(1, 1, 0, 4'b1001, "rst_after_hold");
        hs(1, 1, 0, 4'b1000, "rst_after_idle");
        hs(1, 0, 0, 4'b0011, "rst_after_fall");
        for (int i = 0; i < 3; i++) hs(1, 0, 0, 4'b0001, "rst_after_lowhold");
        hs(1, 0, 0, 4'b0000, "rst_after_lowidle");

        // Second pulse while the first is still high.
        hs(1, 0, 1, 4'b1101, "q_first_rise");
        hs(1, 0, 1, 4'b1001, "q_second_req");
        for (int i = 0; i < 2; i++) hs(1, 0, 0, 4'b1001, "q_hold");
        hs(1, 0, 0, 4'b0011, "q_fall");
        for (int i = 0; i < 3; i++) hs(1, 0, 0, 4'b0001, "q_lowhold");
`ifdef OUTCOND_PULSE_QUEUE_EN
        hs(1, 0, 0, 4'b1101, "q_second_rise");
        for (int i = 0; i < 3; i++) hs(1, 0, 0, 4'b1001, "q_second_hold");
        hs(1, 0, 0, 4'b0011, "q_second_fall");
        for (int i = 0; i < 3; i++) hs(1, 0, 0, 4'b0001, "q_second_lowhold");
        hs(1, 0, 0, 4'b0000, "q_done");
`else
        for (int i = 0; i < 4; i++) hs(1, 0, 0, 4'b0000, "q_dropped");
`endif

        // Rate limiting under a level toggled every cycle.
        mstep(0, 0, 0, "tog_reset");
        edges = 0; strobes = 0; last_edge = -100; prev = pin;
        for (cyc = 0; cyc < 40; cyc++) begin
            mstep(1, cyc[0] ? 1'b0 : 1'b1, 1'b0, "tog_model");
            strobes += int'(rising) + int'(falling);
            if (pin !== prev) begin
                edges++;
                total++;
                if (cyc - last_edge >= T) passed++;
                else $display("FAIL tog_gap: edge gap got %0d required >= %0d", cyc - last_edge, T);
                last_edge = cyc;
            end
            prev = pin;
        end
        total++;
        if (strobes == edges && edges > 0) passed++;
        else $display("FAIL tog_strobes: strobes %0d edges %0d", strobes, edges);

        // Randomized traffic against the model.
        mstep(0, 0, 0, "rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            logic r, l, p;
            r = ($urandom_range(0, 99) != 0);
            l = ($urandom_range(0, 3) == 0) ? ~level_in : level_in;
            p = ($urandom_range(0, 5) == 0);
            mstep(r, l, p, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
